pipe_stage_elastic: RTL and testbench

//  Generic elastic pipeline register between CPU stages (fetch/decode/execute/memory/writeback).

---
 rtl/pipe_stage_elastic_pkg.sv | 5 +
 rtl/pipe_stage_elastic_sat_counter.sv | 13 +
 rtl/pipe_stage_elastic.sv | 100 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline stage registers and their perf counters.
package pipes;
  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t;
  localparam int STALL_CNT_W = 32;
endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)              q <= '0;
    else if (inc && !(&q))  q <= q + 1'b1;
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready register between CPU stages with flush, optional 2-entry skid
// (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_elastic
  import pipes::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_state_t      stateQ, stateN;
  logic [WIDTH-1:0] mainQ, skidQ;
  logic [1:0]       occQ;
  logic             inFire, outFire, loadIn, loadSkid, loadFromSkid;

  assign out_valid = (stateQ != PS_EMPTY);
  assign out_data  = mainQ;
  assign occupancy = occQ;
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;

  // With SKID=0 in_ready already requires out_ready when occupied, so FULL is unreachable.
  always_comb begin
    stateN       = stateQ;
    loadIn       = 1'b0;
    loadSkid     = 1'b0;
    loadFromSkid = 1'b0;
    case (stateQ)
      PS_EMPTY: if (inFire) begin stateN = PS_ONE; loadIn = 1'b1; end
      PS_ONE: begin
        if (inFire && outFire) loadIn = 1'b1;
        else if (inFire)       begin stateN = PS_FULL; loadSkid = 1'b1; end
        else if (outFire)      stateN = PS_EMPTY;
      end
      PS_FULL:  if (outFire) begin stateN = PS_ONE; loadFromSkid = 1'b1; end
      default:  stateN = PS_EMPTY;
    endcase
    if (flush) begin
      stateN       = PS_EMPTY;
      loadIn       = 1'b0;
      loadSkid     = 1'b0;
      loadFromSkid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stateQ <= PS_EMPTY;
      occQ   <= 2'd0;
    end else begin
      stateQ <= stateN;
      case (stateN)
        PS_ONE:  occQ <= 2'd1;
        PS_FULL: occQ <= 2'd2;
        default: occQ <= 2'd0;
      endcase
    end

  always_ff @(posedge clk or posedge reset)
    if (reset)             mainQ <= '0;
    else if (loadIn)       mainQ <= in_data;
    else if (loadFromSkid) mainQ <= skidQ;

  generate
    if (SKID != 0) begin : gSkid
      logic rdyQ;
      // Ready is the registered complement of the next skid-valid, so it stays a pure flop.
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          rdyQ  <= 1'b0;
          skidQ <= '0;
        end else begin
          rdyQ <= (stateN != PS_FULL);
          if (loadSkid) skidQ <= in_data;
        end
      assign in_ready = rdyQ;
    end else begin : gNoSkid
      assign skidQ    = '0;
      assign in_ready = !reset && (!out_valid || out_ready);
    end
  endgenerate

  sat_counter #(.W(CNT_W)) uStall (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .q     (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: SKID=1 stage with a 4-bit stall counter, plus a SKID=0 stage with a scoreboard.
module tb_pipe_stage_elastic;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush1 = 1'b0, v1 = 1'b0, or1 = 1'b0, r1, ov1;
  logic [15:0] d1 = '0, od1;
  logic [1:0]  occ1;
  logic [3:0]  sc1;
  logic        flush0 = 1'b0, v0 = 1'b0, or0 = 1'b0, r0, ov0;
  logic [15:0] d0 = '0, od0;
  logic [1:0]  occ0;
  logic [31:0] sc0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(16), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1), .stall_cnt(sc1));

  pipe_stage_elastic #(.WIDTH(16), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0), .stall_cnt(sc0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] expD;
    int inFires;
    bit  drained;

    // Reset state
    #2;
    chk("rst_in_ready1", 64'(r1), 64'h0);
    chk("rst_in_ready0", 64'(r0), 64'h0);
    chk("rst_out_valid", 64'(ov1), 64'h0);
    chk("rst_out_data", 64'(od1), 64'h0);
    chk("rst_occ", 64'(occ1), 64'h0);
    chk("rst_stall", 64'(sc1), 64'h0);
    step();
    @(negedge clk) reset = 1'b0;
    step();
    chk("rel_in_ready1", 64'(r1), 64'h1);
    chk("rel_in_ready0", 64'(r0), 64'h1);

    // Streaming 0x1..0x10 back-to-back
    or1 = 1'b1; v1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      d1 = 16'(i);
      step();
      chk("str_valid", 64'(ov1), 64'h1);
      chk("str_data", 64'(od1), 64'(i));
      chk("str_ready", 64'(r1), 64'h1);
    end
    v1 = 1'b0;
    step();
    chk("str_empty", 64'(ov1), 64'h0);
    chk("str_occ", 64'(occ1), 64'h0);
    chk("str_stall", 64'(sc1), 64'h0);

    // Backpressure A,B,C
    or1 = 1'b0; v1 = 1'b1; d1 = 16'hA;
    step();
    chk("bp_occA", 64'(occ1), 64'h1);
    chk("bp_rdyA", 64'(r1), 64'h1);
    chk("bp_datA", 64'(od1), 64'hA);
    d1 = 16'hB;
    step();
    chk("bp_occB", 64'(occ1), 64'h2);
    chk("bp_rdyB", 64'(r1), 64'h0);
    chk("bp_datB", 64'(od1), 64'hA);
    chk("bp_scB", 64'(sc1), 64'h1);
    d1 = 16'hC;
    step();
    chk("bp_occC", 64'(occ1), 64'h2);
    chk("bp_rdyC", 64'(r1), 64'h0);
    chk("bp_holdA", 64'(od1), 64'hA);
    step();
    chk("bp_scC", 64'(sc1), 64'h3);
    or1 = 1'b1;
    step();
    chk("bp_outB", 64'(od1), 64'hB);
    chk("bp_occ1", 64'(occ1), 64'h1);
    chk("bp_rdy1", 64'(r1), 64'h1);
    step();
    chk("bp_outC", 64'(od1), 64'hC);
    chk("bp_vldC", 64'(ov1), 64'h1);
    v1 = 1'b0;
    step();
    chk("bp_drained", 64'(ov1), 64'h0);
    chk("bp_sc", 64'(sc1), 64'h3);

    // Flush in FULL (upstream offering 0xD)
    or1 = 1'b0; v1 = 1'b1; d1 = 16'h11;
    step();
    d1 = 16'h12;
    step();
    chk("fl_full", 64'(occ1), 64'h2);
    d1 = 16'hD; flush1 = 1'b1;
    step();
    chk("fl_valid", 64'(ov1), 64'h0);
    chk("fl_occ", 64'(occ1), 64'h0);
    chk("fl_rdy", 64'(r1), 64'h1);
    chk("fl_sc", 64'(sc1), 64'h5);
    flush1 = 1'b0; v1 = 1'b0; or1 = 1'b1;
    step();
    chk("fl_noD", 64'(ov1), 64'h0);
    // Flush with a real in_fire of 0xD while 0x21 is delivered
    v1 = 1'b1; d1 = 16'h21;
    step();
    chk("fl_one", 64'(od1), 64'h21);
    d1 = 16'hD; flush1 = 1'b1;
    step();
    chk("fl_fire_valid", 64'(ov1), 64'h0);
    chk("fl_fire_occ", 64'(occ1), 64'h0);
    flush1 = 1'b0; v1 = 1'b0;
    step();
    chk("fl_fire_noD", 64'(ov1), 64'h0);

    // Stall saturation
    or1 = 1'b0; v1 = 1'b1; d1 = 16'h33;
    step();
    v1 = 1'b0;
    repeat (5) step();
    chk("sat_mid", 64'(sc1), 64'hA);
    repeat (15) step();
    chk("sat_top", 64'(sc1), 64'hF);
    chk("sat_hold_v", 64'(ov1), 64'h1);
    chk("sat_hold_d", 64'(od1), 64'h33);
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    chk("sat_flush_v", 64'(ov1), 64'h0);
    chk("sat_flush_sc", 64'(sc1), 64'hF);

    // Reset mid-traffic from FULL
    v1 = 1'b1; d1 = 16'h41;
    step();
    d1 = 16'h42;
    step();
    chk("mr_full", 64'(occ1), 64'h2);
    reset = 1'b1;
    #1;
    chk("mr_valid", 64'(ov1), 64'h0);
    chk("mr_ready", 64'(r1), 64'h0);
    chk("mr_occ", 64'(occ1), 64'h0);
    chk("mr_sc", 64'(sc1), 64'h0);
    v1 = 1'b0;
    @(negedge clk) reset = 1'b0;
    step();
    chk("mr_rel_ready", 64'(r1), 64'h1);
    chk("mr_rel_valid", 64'(ov1), 64'h0);

    // SKID=0: in_ready follows out_ready combinationally while occupied
    v0 = 1'b1; d0 = 16'h100; or0 = 1'b0;
    step();
    chk("s0_load", 64'(od0), 64'h100);
    chk("s0_occ", 64'(occ0), 64'h1);
    #1; chk("s0_rdy_lo", 64'(r0), 64'h0);
    or0 = 1'b1; #1; chk("s0_rdy_hi", 64'(r0), 64'h1);
    or0 = 1'b0; #1; chk("s0_rdy_lo2", 64'(r0), 64'h0);
    v0 = 1'b0; or0 = 1'b1;
    step();
    chk("s0_drain", 64'(ov0), 64'h0);

    // Alternating out_ready then random stalls, scoreboarded
    inFires = 0;
    d0 = 16'h200;
    for (int c = 0; c < 220; c++) begin
      if (c < 20) begin
        v0  = 1'b1;
        or0 = (c % 2 == 0);
      end else begin
        v0  = ($urandom_range(3) != 0);
        or0 = ($urandom_range(2) != 0);
      end
      #1;
      if (v0 && r0) begin
        q.push_back(d0);
        if (c < 20) inFires++;
      end
      if (ov0 && or0) begin
        expD = (q.size() != 0) ? q.pop_front() : 16'hDEAD;
        chk("sb_data", 64'(od0), 64'(expD));
      end
      if (v0 && r0) begin
        step();
        d0 = d0 + 16'h1;
      end else begin
        step();
      end
      if (c == 19) chk("s0_duty", 64'(inFires), 64'd10);
    end
    v0 = 1'b0; or0 = 1'b1;
    drained = 1'b0;
    for (int c = 0; c < 5 && !drained; c++) begin
      #1;
      if (ov0) begin
        expD = (q.size() != 0) ? q.pop_front() : 16'hDEAD;
        chk("sb_drain", 64'(od0), 64'(expD));
        step();
      end else begin
        drained = 1'b1;
      end
    end
    chk("sb_empty_q", 64'(q.size()), 64'h0);
    chk("sb_empty_v", 64'(ov0), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
